// File: rtl/axi_slave_mem_model.sv
// AXI4 slave memory terminating the master BFM's write and read channels on a word-addressed RAM.
// One outstanding write and one outstanding read; the two channels run independently.
module axi_slave_mem_model #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 1024,
    parameter int AXI4_ID_WIDTH      = 18,
    parameter int MEM_WORDS          = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESETn,
    input  logic [AXI4_ADDRESS_WIDTH-1:0]   AWADDR,
    input  logic [7:0]                      AWLEN,
    input  logic [1:0]                      AWBURST,
    input  logic [AXI4_ID_WIDTH-1:0]        AWID,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [AXI4_DATA_WIDTH-1:0]      WDATA,
    input  logic [AXI4_DATA_WIDTH/8-1:0]    WSTRB,
    input  logic                            WLAST,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [AXI4_ID_WIDTH-1:0]        BID,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [AXI4_ADDRESS_WIDTH-1:0]   ARADDR,
    input  logic [7:0]                      ARLEN,
    input  logic [1:0]                      ARBURST,
    input  logic [AXI4_ID_WIDTH-1:0]        ARID,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [AXI4_ID_WIDTH-1:0]        RID,
    output logic [AXI4_DATA_WIDTH-1:0]      RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RLAST,
    output logic                            RVALID,
    input  logic                            RREADY
);

    localparam int BPW        = AXI4_DATA_WIDTH / 8;
    localparam int WORD_SHIFT = $clog2(BPW);
    localparam int MIDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [AXI4_ADDRESS_WIDTH-1:0] MEM_WORDS_A = AXI4_ADDRESS_WIDTH'(MEM_WORDS);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [AXI4_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Holds both address channels closed for the first cycle out of reset.
    logic ready_en;

    w_state_t                        w_state, w_state_next;
    logic [AXI4_ADDRESS_WIDTH-1:0]   aw_idx;
    logic [7:0]                      aw_len;
    logic [1:0]                      aw_burst;
    logic [AXI4_ID_WIDTH-1:0]        aw_id;
    logic [7:0]                      w_cnt;
    logic                            w_decerr, w_slverr;
    logic                            aw_fire, w_fire, w_last_beat, w_in_range, w_supported;

    r_state_t                        r_state, r_state_next;
    logic [AXI4_ADDRESS_WIDTH-1:0]   ar_idx;
    logic [7:0]                      ar_len;
    logic [1:0]                      ar_burst;
    logic [AXI4_ID_WIDTH-1:0]        ar_id;
    logic [7:0]                      r_cnt;
    logic [AXI4_DATA_WIDTH-1:0]      rdata_q;
    logic [1:0]                      rresp_q;
    logic                            ar_fire, r_fire, r_last, r_load;
    logic [AXI4_ADDRESS_WIDTH-1:0]   rd_idx;
    logic [1:0]                      rd_burst;
    logic [AXI4_DATA_WIDTH-1:0]      rd_word, rd_data;
    logic [1:0]                      rd_resp;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) w_state <= W_IDLE;
        else          w_state <= w_state_next;
    end

    always_comb begin
        w_state_next = w_state;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        BVALID       = 1'b0;
        case (w_state)
            W_IDLE: begin
                AWREADY = ready_en;
                if (AWVALID && ready_en) w_state_next = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && w_last_beat) w_state_next = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign aw_fire     = AWVALID && AWREADY;
    assign w_fire      = WVALID && WREADY;
    assign w_last_beat = (w_cnt == aw_len);
    assign w_in_range  = (aw_idx < MEM_WORDS_A);
    assign w_supported = (aw_burst == BURST_FIXED) || (aw_burst == BURST_INCR);

    // WLAST is cross-checked against the beat counter rather than used to end the burst.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_idx   <= '0;
            aw_len   <= '0;
            aw_burst <= '0;
            aw_id    <= '0;
            w_cnt    <= '0;
            w_decerr <= 1'b0;
            w_slverr <= 1'b0;
        end else if (aw_fire) begin
            aw_idx   <= AWADDR >> WORD_SHIFT;
            aw_len   <= AWLEN;
            aw_burst <= AWBURST;
            aw_id    <= AWID;
            w_cnt    <= '0;
            w_decerr <= 1'b0;
            w_slverr <= 1'b0;
        end else if (w_fire) begin
            if (!w_in_range) w_decerr <= 1'b1;
            if (!w_supported || (WLAST != w_last_beat)) w_slverr <= 1'b1;
            if (aw_burst == BURST_INCR) aw_idx <= aw_idx + 1'b1;
            w_cnt <= w_cnt + 8'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESETn && w_fire && w_in_range && w_supported) begin
            for (int b = 0; b < BPW; b++) begin
                if (WSTRB[b]) mem[aw_idx[MIDX_W-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    assign BID   = aw_id;
    assign BRESP = (w_state != W_RESP) ? RESP_OKAY :
                   w_decerr            ? RESP_DECERR :
                   w_slverr            ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) r_state <= R_IDLE;
        else          r_state <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state;
        ARREADY      = 1'b0;
        RVALID       = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = ready_en;
                if (ARVALID && ready_en) r_state_next = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY && r_last) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    assign ar_fire = ARVALID && ARREADY;
    assign r_fire  = RVALID && RREADY;
    assign r_last  = (r_cnt == ar_len);
    assign r_load  = ar_fire || (r_fire && !r_last);

    // Next beat to present: beat 0 of a new request, or the successor of the current beat.
    always_comb begin
        rd_idx   = ar_idx;
        rd_burst = ar_burst;
        if (ar_fire) begin
            rd_idx   = ARADDR >> WORD_SHIFT;
            rd_burst = ARBURST;
        end else if (ar_burst == BURST_INCR) begin
            rd_idx   = ar_idx + 1'b1;
        end
        rd_word = mem[rd_idx[MIDX_W-1:0]];
        rd_data = rd_word;
        rd_resp = RESP_OKAY;
        if (rd_idx >= MEM_WORDS_A) begin
            rd_data = '0;
            rd_resp = RESP_DECERR;
        end else if ((rd_burst != BURST_FIXED) && (rd_burst != BURST_INCR)) begin
            rd_data = '0;
            rd_resp = RESP_SLVERR;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            ar_idx   <= '0;
            ar_len   <= '0;
            ar_burst <= '0;
            ar_id    <= '0;
            r_cnt    <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            if (ar_fire) begin
                ar_len   <= ARLEN;
                ar_burst <= ARBURST;
                ar_id    <= ARID;
                r_cnt    <= '0;
            end else if (r_fire && !r_last) begin
                r_cnt    <= r_cnt + 8'd1;
            end
            if (r_load) begin
                ar_idx  <= rd_idx;
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end
        end
    end

    assign RID   = ar_id;
    assign RDATA = rdata_q;
    assign RRESP = rresp_q;
    assign RLAST = (r_state == R_DATA) && r_last;

endmodule

// File: tb/tb_axi_slave_mem_model.sv
// Scoreboard bench for axi_slave_mem_model: tasks queue expected B/R responses,
// a negedge monitor pops and compares them on every handshake.
module tb_axi_slave_mem_model;

    localparam int AW        = 32;
    localparam int DW        = 1024;
    localparam int IW        = 18;
    localparam int SW        = DW / 8;
    localparam int MEM_WORDS = 1024;

    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] WRAP = 2'b10;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVE = 2'b10;
    localparam logic [1:0] DECE = 2'b11;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [7:0]    AWLEN, ARLEN;
    logic [1:0]    AWBURST, ARBURST;
    logic [IW-1:0] AWID, ARID;
    logic          AWVALID, AWREADY, ARVALID, ARREADY;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WLAST, WVALID, WREADY;
    logic [IW-1:0] BID, RID;
    logic [1:0]    BRESP, RRESP;
    logic          BVALID, BREADY;
    logic [DW-1:0] RDATA;
    logic          RLAST, RVALID, RREADY;

    int checks = 0;
    int errors = 0;
    int b_seen = 0;
    int r_seen = 0;
    int rready_mode = 0;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_exp_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } r_exp_t;

    b_exp_t b_q[$];
    r_exp_t r_q[$];

    logic [DW-1:0] wdata_tab [16];
    logic [SW-1:0] wstrb_tab [16];

    logic          held_valid = 1'b0;
    logic [DW-1:0] held_data;
    logic [IW+2:0] held_ctrl;

    axi_slave_mem_model #(
        .AXI4_ADDRESS_WIDTH(AW),
        .AXI4_DATA_WIDTH   (DW),
        .AXI4_ID_WIDTH     (IW),
        .MEM_WORDS         (MEM_WORDS)
    ) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .AWADDR  (AWADDR),
        .AWLEN   (AWLEN),
        .AWBURST (AWBURST),
        .AWID    (AWID),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WLAST   (WLAST),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BID     (BID),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARLEN   (ARLEN),
        .ARBURST (ARBURST),
        .ARID    (ARID),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RID     (RID),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RLAST   (RLAST),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h..%h required=%h..%h", name,
                     act[DW-1 -: 64], act[63:0], req[DW-1 -: 64], req[63:0]);
        end
    endtask

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return AWREADY;
            1:       return WREADY;
            default: return ARREADY;
        endcase
    endfunction

    // Valid is already driven; returns how many cycles the handshake took.
    task automatic wait_hs(input int sel, input string name, output int cycles);
        logic hs;
        cycles = 0;
        do begin
            @(negedge ACLK);
            hs = ready_of(sel);
            @(posedge ACLK);
            #1;
            cycles++;
        end while (!hs && cycles < 50);
        if (!hs) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: actual=timeout required=handshake", name);
        end
    endtask

    function automatic void push_r(input logic [IW-1:0] id, input logic [DW-1:0] data,
                                   input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.id   = id;
        e.data = data;
        e.resp = resp;
        e.last = last;
        r_q.push_back(e);
    endfunction

    task automatic apply_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                               input logic [IW-1:0] id, input int wlast_at, input logic [1:0] exp_resp);
        b_exp_t e;
        int cyc;
        int target;
        int n;
        e.id   = id;
        e.resp = exp_resp;
        b_q.push_back(e);
        target = b_seen + 1;
        @(posedge ACLK);
        #1;
        AWADDR  = addr;
        AWLEN   = len;
        AWBURST = burst;
        AWID    = id;
        AWVALID = 1'b1;
        wait_hs(0, "aw_handshake", cyc);
        AWVALID = 1'b0;
        check_output("awready_latency", DW'(cyc), DW'(1));
        for (int i = 0; i <= int'(len); i++) begin
            WDATA  = wdata_tab[i];
            WSTRB  = wstrb_tab[i];
            WLAST  = (i == wlast_at);
            WVALID = 1'b1;
            wait_hs(1, "w_handshake", cyc);
            if (i == 0) check_output("wready_latency", DW'(cyc), DW'(1));
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        @(negedge ACLK);
        check_output("bvalid_after_last", DW'(BVALID), DW'(1));
        n = 0;
        while (b_seen < target && n < 50) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        if (b_seen < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL b_timeout: actual=%0d required=%0d", b_seen, target);
        end
    endtask

    task automatic apply_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input logic [IW-1:0] id);
        int cyc;
        int target;
        int n;
        target = r_seen + int'(len) + 1;
        @(posedge ACLK);
        #1;
        ARADDR  = addr;
        ARLEN   = len;
        ARBURST = burst;
        ARID    = id;
        ARVALID = 1'b1;
        wait_hs(2, "ar_handshake", cyc);
        ARVALID = 1'b0;
        check_output("arready_latency", DW'(cyc), DW'(1));
        @(negedge ACLK);
        check_output("rvalid_latency", DW'(RVALID), DW'(1));
        n = 0;
        while (r_seen < target && n < 100) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        if (r_seen < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL r_timeout: actual=%0d required=%0d", r_seen, target);
        end
    endtask

    // Monitor: stall stability plus scoreboard pops on every B and R handshake.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check_output("r_stall_data", RDATA, held_data);
                check_output("r_stall_ctrl", DW'({RID, RRESP, RLAST}), DW'(held_ctrl));
            end
            held_valid = RVALID && !RREADY;
            held_data  = RDATA;
            held_ctrl  = {RID, RRESP, RLAST};
            if (RVALID && RREADY) begin
                if (r_q.size() == 0) begin
                    check_output("r_unexpected", DW'(1), DW'(0));
                end else begin
                    r_exp_t e;
                    e = r_q.pop_front();
                    check_output("rdata", RDATA, e.data);
                    check_output("rresp", DW'(RRESP), DW'(e.resp));
                    check_output("rlast", DW'(RLAST), DW'(e.last));
                    check_output("rid", DW'(RID), DW'(e.id));
                end
                r_seen++;
            end
            if (BVALID && BREADY) begin
                if (b_q.size() == 0) begin
                    check_output("b_unexpected", DW'(1), DW'(0));
                end else begin
                    b_exp_t e;
                    e = b_q.pop_front();
                    check_output("bresp", DW'(BRESP), DW'(e.resp));
                    check_output("bid", DW'(BID), DW'(e.id));
                end
                b_seen++;
            end
        end
    end

    initial begin
        RREADY = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            case (rready_mode)
                0:       RREADY = 1'b1;
                1:       RREADY = ~RREADY;
                default: RREADY = 1'b0;
            endcase
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        ARESETn = 1'b0;
        AWADDR = '0; AWLEN = '0; AWBURST = '0; AWID = '0; AWVALID = 1'b0;
        ARADDR = '0; ARLEN = '0; ARBURST = '0; ARID = '0; ARVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata_tab[i] = '0;
            wstrb_tab[i] = '1;
        end

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_output("reset_awready", DW'(AWREADY), DW'(0));
        check_output("reset_arready", DW'(ARREADY), DW'(0));
        check_output("reset_wready", DW'(WREADY), DW'(0));
        check_output("reset_valids", DW'({BVALID, RVALID, RLAST}), DW'(0));
        check_output("reset_resp_id", DW'({BRESP, BID, RRESP, RID}), DW'(0));
        check_output("reset_rdata", RDATA, DW'(0));
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        check_output("release_awready", DW'(AWREADY), DW'(1));
        check_output("release_arready", DW'(ARREADY), DW'(1));

        $display("[TB] single write then read");
        wdata_tab[0] = {SW{8'hA5}};
        apply_write(32'h80, 8'd0, INCR, 18'h000A1, 0, OKAY);
        push_r(18'h000B2, {SW{8'hA5}}, OKAY, 1'b1);
        apply_read(32'h80, 8'd0, INCR, 18'h000B2);

        $display("[TB] strobe merge");
        wdata_tab[0] = '1;
        apply_write(32'h100, 8'd0, INCR, 18'h3, 0, OKAY);
        wdata_tab[0] = '0;
        wstrb_tab[0] = SW'(8'h0F);
        apply_write(32'h100, 8'd0, INCR, 18'h4, 0, OKAY);
        wstrb_tab[0] = '1;
        push_r(18'h5, {{(SW-4){8'hFF}}, 32'h0}, OKAY, 1'b1);
        apply_read(32'h100, 8'd0, INCR, 18'h5);

        $display("[TB] INCR burst with read stalls");
        for (int i = 0; i < 8; i++) wdata_tab[i] = DW'(i);
        apply_write(32'h0, 8'd7, INCR, 18'h6, 7, OKAY);
        for (int i = 0; i < 8; i++) push_r(18'h7, DW'(i), OKAY, i == 7);
        rready_mode = 1;
        apply_read(32'h0, 8'd7, INCR, 18'h7);
        rready_mode = 0;

        $display("[TB] out of range burst");
        for (int i = 0; i < 4; i++) wdata_tab[i] = DW'(100 + i);
        apply_write(32'h0001_FF00, 8'd3, INCR, 18'h8, 3, DECE);
        push_r(18'h9, DW'(100), OKAY, 1'b0);
        push_r(18'h9, DW'(101), OKAY, 1'b0);
        push_r(18'h9, DW'(0), DECE, 1'b0);
        push_r(18'h9, DW'(0), DECE, 1'b1);
        apply_read(32'h0001_FF00, 8'd3, INCR, 18'h9);

        $display("[TB] protocol errors");
        for (int i = 0; i < 4; i++) wdata_tab[i] = DW'(50 + i);
        apply_write(32'h800, 8'd3, INCR, 18'hA, 2, SLVE);
        wdata_tab[0] = '0;
        wdata_tab[1] = '0;
        apply_write(32'h80, 8'd1, WRAP, 18'hB, 1, SLVE);
        push_r(18'hC, DW'(1), OKAY, 1'b1);
        apply_read(32'h80, 8'd0, INCR, 18'hC);
        push_r(18'hD, DW'(0), SLVE, 1'b1);
        apply_read(32'h80, 8'd0, WRAP, 18'hD);

        $display("[TB] concurrent write and read");
        for (int i = 0; i < 4; i++) wdata_tab[i] = DW'(200 + i);
        for (int i = 0; i < 8; i++) push_r(18'h2ABCD, DW'(i), OKAY, i == 7);
        fork
            apply_write(32'h1000, 8'd3, INCR, 18'h30001, 3, OKAY);
            apply_read(32'h0, 8'd7, INCR, 18'h2ABCD);
        join

        $display("[TB] reset mid-read");
        begin
            int cyc;
            rready_mode = 2;
            @(posedge ACLK);
            #1;
            ARADDR  = 32'h0;
            ARLEN   = 8'd7;
            ARBURST = INCR;
            ARID    = 18'hE;
            ARVALID = 1'b1;
            wait_hs(2, "ar_handshake_rst", cyc);
            ARVALID = 1'b0;
            repeat (2) @(posedge ACLK);
            #1;
            ARESETn = 1'b0;
            @(negedge ACLK);
            @(negedge ACLK);
            check_output("midreset_rvalid", DW'(RVALID), DW'(0));
            check_output("midreset_arready", DW'(ARREADY), DW'(0));
            @(posedge ACLK);
            #1;
            ARESETn = 1'b1;
            rready_mode = 0;
            @(negedge ACLK);
            @(negedge ACLK);
            check_output("postreset_rvalid", DW'(RVALID), DW'(0));
            check_output("postreset_arready", DW'(ARREADY), DW'(1));
        end
        for (int i = 0; i < 4; i++) push_r(18'hF, DW'(200 + i), OKAY, i == 3);
        apply_read(32'h1000, 8'd3, INCR, 18'hF);
        push_r(18'h10, DW'(1), OKAY, 1'b1);
        apply_read(32'h80, 8'd0, INCR, 18'h10);

        check_output("b_queue_empty", DW'(b_q.size()), DW'(0));
        check_output("r_queue_empty", DW'(r_q.size()), DW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
